vga_delay_line: RTL and testbench
=================================

VGA_DELAY_LINE -- requirements
Module: vga_delay_line

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DELAY, default 2, SHALL set the pipeline depth in cycles; legal range is 1..16.
REQ-003 Parameter CNT_W, default 11, SHALL set the width of hcount and vcount.
REQ-004 Parameter RGB_W, default 12, SHALL set the colour width.
REQ-005 Parameter BLANK_RGB, default 1, SHALL force out_rgb to 0 during blanking when set to 1, and pass colour through unchanged when set to 0.
REQ-006 Parameter FCNT_W, default 16, SHALL set the width of the frame counter.
REQ-007 clk  in  1  system clock, rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 en  in  1  pipeline advance enable.
REQ-010 in_hcount, in_vcount  in  CNT_W each  pixel position.
REQ-011 in_hsync, in_vsync, in_hblnk, in_vblnk  in  1 each  timing flags.
REQ-012 in_rgb  in  RGB_W  pixel colour.
REQ-013 out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk, out_vblnk, out_rgb  out  same widths as inputs  delayed bundle.
REQ-014 out_valid  out  1  high once the pipeline is filled.
REQ-015 frame_start  out  1  single-cycle pulse at output pixel (0,0).
REQ-016 frame_cnt  out  FCNT_W  number of frames seen at the output.

Function
REQ-017 All fields SHALL pass through DELAY register stages, so an input sampled on an en=1 edge appears at the outputs after exactly DELAY en=1 edges.
REQ-018 The register stages SHALL be kept in a shift array; fields SHALL stay mutually aligned, with no per-field skew.
REQ-019 When en=0, all stages and all outputs SHALL hold their values.
REQ-020 When en=0, frame_start SHALL be 0.
REQ-021 When en=0, the fill counter and frame_cnt SHALL hold.
REQ-022 A fill counter SHALL count en=1 edges after reset, saturating at DELAY.
REQ-023 out_valid SHALL be 1 exactly when the fill counter equals DELAY, i.e. registered from the edge on which it reaches DELAY.
REQ-024 With BLANK_RGB=1, the final stage SHALL store 0 as rgb when the incoming hblnk or vblnk is 1, adding no extra latency.
REQ-025 With BLANK_RGB=0, rgb SHALL be delayed unmodified.
REQ-026 frame_start SHALL be registered and aligned with the outputs.
REQ-027 frame_start SHALL be 1 for one cycle when the final stage loads hcount=0 and vcount=0 with en=1, provided the fill counter has reached DELAY on that edge.
REQ-028 frame_start SHALL NOT assert for (0,0) pixels that are still inside an unfilled pipeline.
REQ-029 frame_cnt SHALL increment by 1 on each frame_start cycle, modulo 2^FCNT_W; all-ones wraps to 0 with no flag.
REQ-030 frame_start SHALL NOT be level-extended: consecutive en=1 cycles at (0,0) SHALL pulse once per load event.
REQ-031 Any reset assertion mid-frame SHALL asynchronously clear all stages, out_valid, frame_start and frame_cnt.
REQ-032 After a mid-frame reset, refill SHALL restart from zero.
REQ-033 All outputs SHALL be driven directly from flip-flops, with no combinational input-to-output path.

Reset
REQ-034 On rst_n=0, all pipeline stages SHALL immediately clear to 0: counts 0, flags 0, rgb 0.
REQ-035 On rst_n=0, out_valid, frame_start, frame_cnt and the fill counter SHALL immediately be 0.
REQ-036 Reset release SHALL be synchronised externally; the first en=1 edge after deassertion SHALL be the first loading edge.

Verification
REQ-037 Latency: DELAY=2, en=1, ramp in_hcount 0,1,2,... -> out_hcount equals the input from 2 cycles earlier; out_valid rises on the 2nd edge after reset release.
REQ-038 Stall: DELAY=3, toggle en 1,0,0,1 -> outputs frozen during en=0 cycles; total latency counts only en=1 edges; no frame_start during stall.
REQ-039 Blanking: BLANK_RGB=1, in_rgb=12'hFFF with in_hblnk=1 -> out_rgb=12'h000 after DELAY; repeat with BLANK_RGB=0 -> out_rgb=12'hFFF.
REQ-040 Frame pulse and wrap: feed 800x600 timing with FCNT_W=2 for 5 frames -> frame_start one cycle per frame, aligned with out (0,0); frame_cnt runs 1,2,3,0,1.
REQ-041 Startup (0,0): reset, then present (0,0) on the first input cycle with DELAY=2 -> frame_start on the 2nd edge (pipeline just filled); no spurious pulse from reset zeros before the fill.
REQ-042 Mid-frame reset: assert rst_n=0 asynchronously at hcount=400 -> all outputs 0 within the same cycle, without waiting for a clock edge; after release, out_valid low for DELAY en=1 edges.

Source files
------------

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - fixed-latency VGA timing/colour delay line with fill tracking and frame counter
module vga_delay_line #(
    parameter int DELAY     = 2,
    parameter int CNT_W     = 11,
    parameter int RGB_W     = 12,
    parameter int BLANK_RGB = 1,
    parameter int FCNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [CNT_W-1:0]  in_hcount,
    input  logic [CNT_W-1:0]  in_vcount,
    input  logic              in_hsync,
    input  logic              in_vsync,
    input  logic              in_hblnk,
    input  logic              in_vblnk,
    input  logic [RGB_W-1:0]  in_rgb,
    output logic [CNT_W-1:0]  out_hcount,
    output logic [CNT_W-1:0]  out_vcount,
    output logic              out_hsync,
    output logic              out_vsync,
    output logic              out_hblnk,
    output logic              out_vblnk,
    output logic [RGB_W-1:0]  out_rgb,
    output logic              out_valid,
    output logic              frame_start,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int FW = $clog2(DELAY + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(DELAY);
    localparam logic [FW-1:0] FILL_PRE = FW'(DELAY - 1);

    typedef struct packed {
        logic [CNT_W-1:0] hcount;
        logic [CNT_W-1:0] vcount;
        logic             hsync;
        logic             vsync;
        logic             hblnk;
        logic             vblnk;
        logic [RGB_W-1:0] rgb;
    } pix_t;

    pix_t              stage [DELAY];
    pix_t              in_pix;
    pix_t              tail_pix;
    pix_t              load_pix;
    logic [FW-1:0]     fill_cnt;
    logic              valid_q;
    logic              fs_q;
    logic [FCNT_W-1:0] fcnt_q;
    logic              fill_hit;
    logic              load_origin;
    logic              out_origin;
    logic              fs_next;

    assign in_pix = {in_hcount, in_vcount, in_hsync, in_vsync, in_hblnk, in_vblnk, in_rgb};

    // Word about to enter the final stage; blanking is applied here so it costs no extra cycle.
    generate
        if (DELAY == 1) begin : g_tail_in
            assign tail_pix = in_pix;
        end else begin : g_tail_stage
            assign tail_pix = stage[DELAY-2];
        end
    endgenerate

    always_comb begin
        load_pix = tail_pix;
        if ((BLANK_RGB != 0) && (tail_pix.hblnk || tail_pix.vblnk)) begin
            load_pix.rgb = '0;
        end
    end

    // The edge that loads a pixel into the final stage is the edge on which the fill count reaches DELAY.
    always_comb begin
        fill_hit    = (fill_cnt >= FILL_PRE);
        load_origin = (load_pix.hcount == '0) && (load_pix.vcount == '0);
        out_origin  = (stage[DELAY-1].hcount == '0) && (stage[DELAY-1].vcount == '0);
        // A valid (0,0) already on the output means this load repeats it rather than starting a frame.
        fs_next     = load_origin && fill_hit && !(valid_q && out_origin);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DELAY; i++) begin
                stage[i] <= '0;
            end
            fill_cnt <= '0;
            valid_q  <= 1'b0;
            fs_q     <= 1'b0;
            fcnt_q   <= '0;
        end else if (en) begin
            for (int i = DELAY - 1; i > 0; i--) begin
                stage[i] <= stage[i-1];
            end
            stage[0]       <= in_pix;
            stage[DELAY-1] <= load_pix;
            if (fill_cnt != FILL_MAX) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
            valid_q <= fill_hit;
            fs_q    <= fs_next;
            if (fs_next) begin
                fcnt_q <= fcnt_q + 1'b1;
            end
        end else begin
            fs_q <= 1'b0;
        end
    end

    assign out_hcount  = stage[DELAY-1].hcount;
    assign out_vcount  = stage[DELAY-1].vcount;
    assign out_hsync   = stage[DELAY-1].hsync;
    assign out_vsync   = stage[DELAY-1].vsync;
    assign out_hblnk   = stage[DELAY-1].hblnk;
    assign out_vblnk   = stage[DELAY-1].vblnk;
    assign out_rgb     = stage[DELAY-1].rgb;
    assign out_valid   = valid_q;
    assign frame_start = fs_q;
    assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_vga_delay_line.sv
// tb/tb_vga_delay_line.sv - scoreboard bench for vga_delay_line at two parameter sets
module tb_vga_delay_line;

    localparam int H_TOT = 420;
    localparam int H_ACT = 400;
    localparam int V_TOT = 6;
    localparam int V_ACT = 4;

    typedef struct packed {
        logic [10:0] hc;
        logic [10:0] vc;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
    } pix_t;

    typedef struct packed {
        pix_t        o;
        logic        valid;
        logic        fs;
        logic [15:0] fc;
        logic [4:0]  fill;
    } mstate_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [10:0] in_hcount, in_vcount;
    logic        in_hsync, in_vsync, in_hblnk, in_vblnk;
    logic [11:0] in_rgb;

    logic [10:0] a_hc, a_vc, b_hc, b_vc;
    logic        a_hs, a_vs, a_hb, a_vb, a_valid, a_fs;
    logic        b_hs, b_vs, b_hb, b_vb, b_valid, b_fs;
    logic [11:0] a_rgb, b_rgb;
    logic [1:0]  a_fc;
    logic [15:0] b_fc;

    int tests = 0;
    int fails = 0;
    int pulses_a = 0;
    int pulses_b = 0;

    pix_t    qa[$];
    pix_t    qb[$];
    mstate_t ma, mb;

    always #5 clk = ~clk;

    vga_delay_line #(.DELAY(2), .CNT_W(11), .RGB_W(12), .BLANK_RGB(1), .FCNT_W(2)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en),
        .in_hcount(in_hcount), .in_vcount(in_vcount),
        .in_hsync(in_hsync), .in_vsync(in_vsync), .in_hblnk(in_hblnk), .in_vblnk(in_vblnk),
        .in_rgb(in_rgb),
        .out_hcount(a_hc), .out_vcount(a_vc), .out_hsync(a_hs), .out_vsync(a_vs),
        .out_hblnk(a_hb), .out_vblnk(a_vb), .out_rgb(a_rgb),
        .out_valid(a_valid), .frame_start(a_fs), .frame_cnt(a_fc)
    );

    vga_delay_line #(.DELAY(3), .CNT_W(11), .RGB_W(12), .BLANK_RGB(0), .FCNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en),
        .in_hcount(in_hcount), .in_vcount(in_vcount),
        .in_hsync(in_hsync), .in_vsync(in_vsync), .in_hblnk(in_hblnk), .in_vblnk(in_vblnk),
        .in_rgb(in_rgb),
        .out_hcount(b_hc), .out_vcount(b_vc), .out_hsync(b_hs), .out_vsync(b_vs),
        .out_hblnk(b_hb), .out_vblnk(b_vb), .out_rgb(b_rgb),
        .out_valid(b_valid), .frame_start(b_fs), .frame_cnt(b_fc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic mstate_t advance(mstate_t s, logic have, pix_t p, int d, int blank, int fw);
        logic prev_zero;
        prev_zero = s.valid && (s.o.hc == 0) && (s.o.vc == 0);
        if (s.fill < 5'(d)) s.fill = s.fill + 5'd1;
        s.fs = 1'b0;
        if (have) begin
            if (blank != 0 && (p.hb || p.vb)) p.rgb = 12'h000;
            s.o  = p;
            s.fs = (p.hc == 0) && (p.vc == 0) && (s.fill == 5'(d)) && !prev_zero;
        end
        if (s.fs) s.fc = 16'((32'(s.fc) + 1) & ((32'd1 << fw) - 1));
        s.valid = (s.fill == 5'(d));
        return s;
    endfunction

    task automatic set_pix(input int h, input int v);
        in_hcount = 11'(h);
        in_vcount = 11'(v);
        in_hblnk  = (h >= H_ACT);
        in_vblnk  = (v >= V_ACT);
        in_hsync  = (h >= 405) && (h < 410);
        in_vsync  = (v == 5);
        in_rgb    = (in_hblnk || in_vblnk) ? 12'hFFF : 12'(h * 7 + v * 3 + 1);
    endtask

    task automatic cmp_all();
        chk("a_hc", 32'(a_hc), 32'(ma.o.hc));    chk("b_hc", 32'(b_hc), 32'(mb.o.hc));
        chk("a_vc", 32'(a_vc), 32'(ma.o.vc));    chk("b_vc", 32'(b_vc), 32'(mb.o.vc));
        chk("a_flags", {28'd0, a_hs, a_vs, a_hb, a_vb}, {28'd0, ma.o.hs, ma.o.vs, ma.o.hb, ma.o.vb});
        chk("b_flags", {28'd0, b_hs, b_vs, b_hb, b_vb}, {28'd0, mb.o.hs, mb.o.vs, mb.o.hb, mb.o.vb});
        chk("a_rgb", 32'(a_rgb), 32'(ma.o.rgb)); chk("b_rgb", 32'(b_rgb), 32'(mb.o.rgb));
        chk("a_valid", 32'(a_valid), 32'(ma.valid)); chk("b_valid", 32'(b_valid), 32'(mb.valid));
        chk("a_fs", 32'(a_fs), 32'(ma.fs));      chk("b_fs", 32'(b_fs), 32'(mb.fs));
        chk("a_fc", 32'(a_fc), 32'(ma.fc));      chk("b_fc", 32'(b_fc), 32'(mb.fc));
    endtask

    task automatic step(input logic e);
        pix_t cur, pa, pb;
        logic ha, hb;
        cur = {in_hcount, in_vcount, in_hsync, in_vsync, in_hblnk, in_vblnk, in_rgb};
        en = e;
        @(posedge clk);
        #1;
        if (e) begin
            qa.push_back(cur);
            qb.push_back(cur);
            ha = (qa.size() == 2);
            hb = (qb.size() == 3);
            pa = ha ? qa.pop_front() : '0;
            pb = hb ? qb.pop_front() : '0;
            ma = advance(ma, ha, pa, 2, 1, 2);
            mb = advance(mb, hb, pb, 3, 0, 16);
        end else begin
            ma.fs = 1'b0;
            mb.fs = 1'b0;
        end
        cmp_all();
        if (a_fs) pulses_a++;
        if (b_fs) pulses_b++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a_bus"}, {a_hc, a_vc, a_hs, a_vs, a_hb, a_vb, 2'b00}, 32'd0);
        chk({tag, "_b_bus"}, {b_hc, b_vc, b_hs, b_vs, b_hb, b_vb, 2'b00}, 32'd0);
        chk({tag, "_rgb"}, {a_rgb, b_rgb, 8'd0}, 32'd0);
        chk({tag, "_ctl"}, {a_valid, a_fs, b_valid, b_fs, 28'd0}, 32'd0);
        chk({tag, "_fc"}, {14'd0, a_fc, b_fc}, 32'd0);
    endtask

    task automatic reset_model();
        ma = '0;
        mb = '0;
        qa.delete();
        qb.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        set_pix(0, 0);
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        // Five frames starting with (0,0) on the first loading edge, directed and random stalls mixed in.
        for (int f = 0; f < 5; f++) begin
            for (int v = 0; v < V_TOT; v++) begin
                for (int h = 0; h < H_TOT; h++) begin
                    if ((f == 0 && v == 0 && h == 3) || (f > 0 && $urandom_range(0, 15) == 0)) begin
                        set_pix($urandom_range(0, H_TOT - 1), $urandom_range(0, V_TOT - 1));
                        step(1'b0);
                        if (f == 0) chk("stall_fs", 32'(a_fs), 32'd0);
                        step(1'b0);
                    end
                    set_pix(h, v);
                    step(1'b1);
                    if (f == 0 && v == 0 && h == 0) chk("start_valid_e1", 32'(a_valid), 32'd0);
                    if (f == 0 && v == 0 && h == 1) begin
                        chk("start_fs_e2", 32'(a_fs), 32'd1);
                        chk("start_valid_e2", 32'(a_valid), 32'd1);
                        chk("start_hc_e2", 32'(a_hc), 32'd0);
                    end
                    if (f == 0 && v == 0 && h == H_ACT + 2) begin
                        chk("blank_rgb_a", 32'(a_rgb), 32'h000);
                        chk("blank_rgb_b", 32'(b_rgb), 32'hFFF);
                    end
                end
            end
        end
        set_pix(1, 0);
        repeat (3) step(1'b1);
        chk("pulses_a", 32'(pulses_a), 32'd5);
        chk("pulses_b", 32'(pulses_b), 32'd5);
        chk("fc_wrap_a", 32'(a_fc), 32'd1);
        chk("fc_b", 32'(b_fc), 32'd5);

        // Mid-line asynchronous reset at hcount=400.
        for (int h = 0; h <= 400; h++) begin
            set_pix(h, 1);
            step(1'b1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        reset_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Refill after reset with (0,0) held for three loads: one pulse only.
        pulses_a = 0;
        pulses_b = 0;
        set_pix(0, 0);
        step(1'b1);
        chk("refill_a_e1", 32'(a_valid), 32'd0);
        step(1'b1);
        chk("refill_a_e2", 32'(a_valid), 32'd1);
        chk("refill_b_e2", 32'(b_valid), 32'd0);
        step(1'b1);
        chk("refill_b_e3", 32'(b_valid), 32'd1);
        for (int h = 1; h < 20; h++) begin
            set_pix(h, 0);
            step(1'b1);
        end
        chk("repeat_origin_a", 32'(pulses_a), 32'd1);
        chk("repeat_origin_b", 32'(pulses_b), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
